// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, ALU operations,
// immediate formats and the canonical NOP.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

endpackage

// File: rtl/decode_stage_inst_decoder.sv
// Combinational RV32I decoder: instruction word to register
// fields, immediate, ALU op and control strobes.
module inst_decoder
  import decode_pkg::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [31:0] imm,
  output alu_op_e     alu_op,
  output logic        we_gpr,
  output logic        mem_read,
  output logic        mem_write,
  output logic        bcond,
  output logic        adv_gpr,
  output logic        adv_imm,
  output logic        bad
);

  logic [6:0] op;
  logic [6:0] funct7;
  imm_fmt_e   fmt;
  logic       known;
  logic       wb;
  logic       rd_mem;
  logic       wr_mem;
  logic       br;
  logic       jr;
  logic       jmp;

  assign op     = inst[6:0];
  assign funct7 = inst[31:25];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];

  function automatic alu_op_e alu_sel(
    input logic [2:0] f3,
    input logic       alt,
    input logic       is_op
  );
    alu_op_e r;
    unique case (f3)
      3'd0:    r = (is_op && alt) ? ALU_SUB : ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = alt ? ALU_SRA : ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // Opcode classification: format, ALU op and raw strobes.
  always_comb begin
    fmt    = IMM_NONE;
    alu_op = ALU_ADD;
    known  = 1'b1;
    wb     = 1'b0;
    rd_mem = 1'b0;
    wr_mem = 1'b0;
    br     = 1'b0;
    jr     = 1'b0;
    jmp    = 1'b0;
    unique case (op)
      OPC_LUI: begin
        fmt    = IMM_U;
        alu_op = ALU_PASS_B;
        wb     = 1'b1;
      end
      OPC_AUIPC: begin
        fmt = IMM_U;
        wb  = 1'b1;
      end
      OPC_JAL: begin
        fmt = IMM_J;
        wb  = 1'b1;
        jmp = 1'b1;
      end
      OPC_JALR: begin
        fmt = IMM_I;
        wb  = 1'b1;
        jmp = 1'b1;
        jr  = 1'b1;
      end
      OPC_BRANCH: begin
        fmt    = IMM_B;
        alu_op = ALU_SUB;
        br     = 1'b1;
      end
      OPC_LOAD: begin
        fmt    = IMM_I;
        wb     = 1'b1;
        rd_mem = 1'b1;
      end
      OPC_STORE: begin
        fmt    = IMM_S;
        wr_mem = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt    = IMM_I;
        wb     = 1'b1;
        alu_op = alu_sel(inst[14:12], inst[30], 1'b0);
      end
      OPC_OP: begin
        wb     = 1'b1;
        alu_op = alu_sel(inst[14:12], inst[30], 1'b1);
        known  = (funct7 == 7'h00) || (funct7 == 7'h20);
      end
      default: known = 1'b0;
    endcase
  end

  // Immediate assembly with sign extension from the top bit.
  always_comb begin
    imm = 32'h0;
    unique case (fmt)
      IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm = {inst[31:12], 12'h0};
      IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

  assign bad       = (inst[1:0] != 2'b11) || !known;
  assign we_gpr    = wb && (rd != 5'd0) && !bad;
  assign mem_read  = rd_mem && !bad;
  assign mem_write = wr_mem && !bad;
  assign bcond     = br && !bad;
  assign adv_gpr   = jr && !bad;
  assign adv_imm   = jmp && !bad;

endmodule

// File: rtl/decode_stage.sv
// IF/ID pipeline register with valid/stall/flush handshake,
// retired-instruction counter and sticky illegal flag.
module decode_stage
  import decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   _clk,
  input  logic                   _reset,
  input  logic [31:0]            _pc,
  input  logic [31:0]            _inst,
  input  logic                   _valid,
  input  logic                   _stall,
  input  logic                   _flush,
  input  logic                   _en_trace,
  output logic                   ready_,
  output logic                   valid_,
  output logic [31:0]            pc_,
  output logic [31:0]            inst_,
  output logic [4:0]             rs1_,
  output logic [4:0]             rs2_,
  output logic [4:0]             rd_,
  output logic [2:0]             funct3_,
  output logic [31:0]            imm_,
  output alu_op_e                alu_op_,
  output logic                   we_gpr_,
  output logic                   mem_read_,
  output logic                   mem_write_,
  output logic                   sig_bcond_,
  output logic                   sig_advance_gpr_,
  output logic                   sig_advance_by_imm_,
  output logic                   illegal_,
  output logic [COUNT_WIDTH-1:0] inst_count_
);

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  logic dec_bad;
  logic retire;

  assign ready_ = !valid_ || !_stall;
  assign retire = valid_ && !_stall && !_flush;

  // Pipeline register: reset > flush > stall > load.
  always_ff @(posedge _clk) begin
    if (_reset) begin
      valid_ <= 1'b0;
      pc_    <= RESET_PC;
      inst_  <= NOP;
    end else if (_flush) begin
      valid_ <= 1'b0;
    end else if (ready_) begin
      valid_ <= _valid;
      if (_valid) begin
        pc_   <= _pc;
        inst_ <= _inst;
      end
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge _clk) begin
    if (_reset) begin
      inst_count_ <= '0;
    end else if (retire) begin
      inst_count_ <= inst_count_ + ONE;
    end
  end

  // Sticky illegal flag, cleared only by reset.
  always_ff @(posedge _clk) begin
    if (_reset) begin
      illegal_ <= 1'b0;
    end else if (valid_ && dec_bad && !_flush) begin
      illegal_ <= 1'b1;
    end
  end

  inst_decoder u_dec (
    .inst      (inst_),
    .rs1       (rs1_),
    .rs2       (rs2_),
    .rd        (rd_),
    .funct3    (funct3_),
    .imm       (imm_),
    .alu_op    (alu_op_),
    .we_gpr    (we_gpr_),
    .mem_read  (mem_read_),
    .mem_write (mem_write_),
    .bcond     (sig_bcond_),
    .adv_gpr   (sig_advance_gpr_),
    .adv_imm   (sig_advance_by_imm_),
    .bad       (dec_bad)
  );

`ifndef SYNTHESIS
  // Trace each captured fetch when enabled.
  always @(posedge _clk) begin
    if (!_reset && !_flush && ready_ && _valid && _en_trace)
      $display("decode trace: pc=%08h inst=%08h", _pc, _inst);
  end
`endif

endmodule
